// File: rtl/ddr3_axi_arb_pkg.sv
// ddr3_axi_arb_pkg: shared types and constants for the two-master DDR3 AXI4 arbiter.
// Provides the read/write FSM state enums, downstream ID width (ID_W), master ID width (MID_W)
// and the OKAY response code.
package ddr3_axi_arb_pkg;
  localparam int ID_W = 4;
  localparam int MID_W = 3;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  typedef enum logic {R_IDLE, R_ADDR} rd_state_t;
  typedef enum logic {W_IDLE, W_BUSY} wr_state_t;
endpackage

// File: rtl/ddr3_axi_arb_if.sv
// ddr3_axi_arb_if: AXI4 bundle (AW/W/B/AR/R) used for both upstream masters and the ddr3_top port.
// Parameters: ADDR_W, DATA_W (strobe width DATA_W/8), ID_W (3 on masters, 4 towards ddr3_top).
// Modports: master drives requests and response readies; slave drives request readies and responses.
interface ddr3_axi_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid, arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ddr3_axi_arb_rr.sv
// ddr3_axi_arb_rr: 2-way grant unit shared by the read and write arbitration paths.
// Ports: clk, rst_n (async, active-low), req[1:0] per-master requests, take (grant is being
// registered this cycle), sel (index of the master that wins if take is high).
// Default: round-robin on a last-granted pointer that resets to 1 so master 0 wins the first tie.
// With DDR3_AXI_ARB_PRIO_EN: master 0 has strict priority, but a 4-bit starvation counter forces a
// master-1 grant once STARVE_MAX master-0 grants were made while master 1 was waiting.
module ddr3_axi_arb_rr #(
  parameter int STARVE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       sel
);
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX must fit the 4-bit starvation counter");
  end
`ifdef DDR3_AXI_ARB_PRIO_EN
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    sel = req[1] & (~req[0] | (cnt_q >= 4'(STARVE_MAX)));
    cnt_d = !take ? cnt_q : sel ? 4'd0 : req[1] ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  end
`else
  logic ptr_q, ptr_d;
  always_comb begin
    sel = &req ? ~ptr_q : req[1];
    ptr_d = take ? sel : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else ptr_q <= ptr_d;
  end
`endif
endmodule

// File: rtl/ddr3_axi_arb.sv
// ddr3_axi_arb: two-master AXI4 arbiter in front of the single ddr3_top AXI4 slave port.
// Ports: clk, rst_n (async, active-low), m0/m1 (upstream masters, 3-bit IDs, slave modport),
// s (towards ddr3_top, 4-bit IDs, master modport).
// Read and write paths are arbitrated independently; the winning master's index becomes ID bit 3
// downstream so R and B are steered back by that bit without any tracking state.
// Optional macro DDR3_AXI_ARB_PRIO_EN: master-0 priority with starvation limit STARVE_MAX.
module ddr3_axi_arb
  import ddr3_axi_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 15
) (
  input logic           clk,
  input logic           rst_n,
  ddr3_axi_arb_if.slave  m0,
  ddr3_axi_arb_if.slave  m1,
  ddr3_axi_arb_if.master s
);
  rd_state_t rd_state_q, rd_state_d;
  wr_state_t wr_state_q, wr_state_d;
  logic rg_q, rg_d, wg_q, wg_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rd_sel, wr_sel, rd_take, wr_take, rd_act, wr_act, aw_fin, w_fin;
  logic [ADDR_W-1:0] ar_addr, aw_addr;
  logic [DATA_W-1:0] w_data;

  ddr3_axi_arb_rr #(.STARVE_MAX(STARVE_MAX)) u_rd_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({m1.arvalid, m0.arvalid}),
    .take (rd_take),
    .sel  (rd_sel)
  );

  ddr3_axi_arb_rr #(.STARVE_MAX(STARVE_MAX)) u_wr_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({m1.awvalid, m0.awvalid}),
    .take (wr_take),
    .sel  (wr_sel)
  );

  // Read address path: the grant is registered in R_IDLE, so it is frozen while s.arvalid is high.
  always_comb begin
    rd_act = rd_state_q == R_ADDR;
    rd_take = rd_state_q == R_IDLE && (m0.arvalid || m1.arvalid);
    ar_addr = rg_q ? m1.araddr : m0.araddr;
    s.arvalid = rd_act & (rg_q ? m1.arvalid : m0.arvalid);
    s.arid = {rg_q, rg_q ? m1.arid : m0.arid};
    s.araddr = ar_addr;
    s.arlen = rg_q ? m1.arlen : m0.arlen;
    s.arburst = rg_q ? m1.arburst : m0.arburst;
    m0.arready = rd_act & ~rg_q & s.arready;
    m1.arready = rd_act & rg_q & s.arready;
    rd_state_d = rd_take ? R_ADDR : (s.arvalid && s.arready) ? R_IDLE : rd_state_q;
    rg_d = rd_take ? rd_sel : rg_q;
  end

  // Write path: AW and W of the granted master are forwarded independently; each side is closed by
  // a sticky done flag and the grant is released once both sides have completed.
  always_comb begin
    wr_act = wr_state_q == W_BUSY;
    wr_take = wr_state_q == W_IDLE && (m0.awvalid || m1.awvalid);
    aw_addr = wg_q ? m1.awaddr : m0.awaddr;
    w_data = wg_q ? m1.wdata : m0.wdata;
    s.awvalid = wr_act & ~aw_done_q & (wg_q ? m1.awvalid : m0.awvalid);
    s.awid = {wg_q, wg_q ? m1.awid : m0.awid};
    s.awaddr = aw_addr;
    s.awlen = wg_q ? m1.awlen : m0.awlen;
    s.awburst = wg_q ? m1.awburst : m0.awburst;
    s.wvalid = wr_act & ~w_done_q & (wg_q ? m1.wvalid : m0.wvalid);
    s.wdata = w_data;
    s.wstrb = wg_q ? m1.wstrb : m0.wstrb;
    s.wlast = wg_q ? m1.wlast : m0.wlast;
    m0.awready = wr_act & ~wg_q & ~aw_done_q & s.awready;
    m1.awready = wr_act & wg_q & ~aw_done_q & s.awready;
    m0.wready = wr_act & ~wg_q & ~w_done_q & s.wready;
    m1.wready = wr_act & wg_q & ~w_done_q & s.wready;
    aw_fin = aw_done_q | (s.awvalid & s.awready);
    w_fin = w_done_q | (s.wvalid & s.wready & s.wlast);
    aw_done_d = wr_act & aw_fin & ~w_fin;
    w_done_d = wr_act & w_fin & ~aw_fin;
    wr_state_d = wr_take ? W_BUSY : (wr_act && aw_fin && w_fin) ? W_IDLE : wr_state_q;
    wg_d = wr_take ? wr_sel : wg_q;
  end

  // Responses are steered by downstream ID bit 3; rst_n gating keeps valid/ready low during reset
  // even if ddr3_top is still presenting a response.
  always_comb begin
    s.rready = rst_n & (s.rid[ID_W-1] ? m1.rready : m0.rready);
    m0.rvalid = rst_n & s.rvalid & ~s.rid[ID_W-1];
    m1.rvalid = rst_n & s.rvalid & s.rid[ID_W-1];
    m0.rid = s.rid[MID_W-1:0];
    m1.rid = s.rid[MID_W-1:0];
    m0.rdata = s.rdata;
    m1.rdata = s.rdata;
    m0.rresp = s.rresp;
    m1.rresp = s.rresp;
    m0.rlast = s.rlast;
    m1.rlast = s.rlast;
    s.bready = rst_n & (s.bid[ID_W-1] ? m1.bready : m0.bready);
    m0.bvalid = rst_n & s.bvalid & ~s.bid[ID_W-1];
    m1.bvalid = rst_n & s.bvalid & s.bid[ID_W-1];
    m0.bid = s.bid[MID_W-1:0];
    m1.bid = s.bid[MID_W-1:0];
    m0.bresp = s.bresp;
    m1.bresp = s.bresp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rg_q <= 1'b0;
      wg_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rg_q <= rg_d;
      wg_q <= wg_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
endmodule

// File: tb/tb_ddr3_axi_arb.sv
// tb_ddr3_axi_arb: directed and randomized self-checking bench for ddr3_axi_arb.
module tb_ddr3_axi_arb;
  import ddr3_axi_arb_pkg::*;
  localparam int SM = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  ddr3_axi_arb_if #(.ID_W(3)) m0 ();
  ddr3_axi_arb_if #(.ID_W(3)) m1 ();
  ddr3_axi_arb_if #(.ID_W(4)) s ();

  ddr3_axi_arb #(.STARVE_MAX(SM)) dut (.clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .s(s));

  // reference model state for the randomized read-arbitration run
  logic mb, mw, mlast, s_ardy;
  int mcnt;
  logic [1:0] req;
  logic [2:0] q_id [2];
  logic [31:0] q_ad [2];
  logic [7:0] q_ln [2];
  logic [1:0] q_bu [2];
  logic [3:0] rids [3];
  logic rv, rl, rr0, rr1, bv, br0, br1;
  logic [3:0] ri, bi;
  logic [31:0] rd;
  logic [1:0] rs, bs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    chk(tag, 64'({s.arvalid, s.awvalid, s.wvalid, s.rready, s.bready,
                  m0.arready, m0.awready, m0.wready, m0.rvalid, m0.bvalid,
                  m1.arready, m1.awready, m1.wready, m1.rvalid, m1.bvalid}), 64'd0);
  endtask

  task automatic clr;
    m0.awid = '0; m0.awaddr = '0; m0.awlen = '0; m0.awburst = '0; m0.awvalid = 0;
    m0.wdata = '0; m0.wstrb = '0; m0.wlast = 0; m0.wvalid = 0; m0.bready = 0;
    m0.arid = '0; m0.araddr = '0; m0.arlen = '0; m0.arburst = '0; m0.arvalid = 0; m0.rready = 0;
    m1.awid = '0; m1.awaddr = '0; m1.awlen = '0; m1.awburst = '0; m1.awvalid = 0;
    m1.wdata = '0; m1.wstrb = '0; m1.wlast = 0; m1.wvalid = 0; m1.bready = 0;
    m1.arid = '0; m1.araddr = '0; m1.arlen = '0; m1.arburst = '0; m1.arvalid = 0; m1.rready = 0;
    s.awready = 0; s.wready = 0; s.arready = 0;
    s.bid = '0; s.bresp = '0; s.bvalid = 0;
    s.rid = '0; s.rdata = '0; s.rresp = '0; s.rlast = 0; s.rvalid = 0;
  endtask

  // arbitration rule from the specification, applied when a grant is registered
  function automatic logic pick(input logic [1:0] r);
`ifdef DDR3_AXI_ARB_PRIO_EN
    return &r ? (mcnt >= SM) : r[1];
`else
    return &r ? ~mlast : r[1];
`endif
  endfunction

  initial begin
    clr();
    rst_n = 0;
    m0.arvalid = 1; m1.arvalid = 1; m0.awvalid = 1; m1.awvalid = 1; m0.wvalid = 1; m1.wvalid = 1;
    m0.rready = 1; m1.rready = 1; m0.bready = 1; m1.bready = 1;
    s.arready = 1; s.awready = 1; s.wready = 1; s.rvalid = 1; s.bvalid = 1; s.rid = 4'h8;
    #2 quiet("reset_outs");
    tick; tick;
    // read tie after reset: m0 first, then m1
    clr();
    m0.arvalid = 1; m0.arid = 3'd5; m0.araddr = 32'h100; m0.arlen = 8'd3; m0.arburst = 2'd1;
    m1.arvalid = 1; m1.arid = 3'd2; m1.araddr = 32'h200;
    s.arready = 1;
    rst_n = 1;
    #2 chk("ar_idle0", 64'(s.arvalid), 64'd0);
    tick;
    #2 chk("ar_m0", 64'({s.arvalid, s.arid, s.araddr, s.arlen, s.arburst}), 64'({1'b1, 4'h5, 32'h100, 8'd3, 2'd1}));
    chk("ar_m0_rdy", 64'({m1.arready, m0.arready}), 64'(2'b01));
    tick; m0.arvalid = 0;
    #2 chk("ar_gap", 64'(s.arvalid), 64'd0);
    tick;
    #2 chk("ar_m1", 64'({s.arvalid, s.arid, s.araddr}), 64'({1'b1, 4'hA, 32'h200}));
    chk("ar_m1_rdy", 64'({m1.arready, m0.arready}), 64'(2'b10));
    tick; m1.arvalid = 0;
    s.rvalid = 1; s.rid = 4'hA; s.rdata = 32'hCAFE0001; m0.rready = 1; m1.rready = 1;
    #2 chk("r_to_m1", 64'({m1.rvalid, m0.rvalid, m1.rid, m1.rdata}), 64'({1'b1, 1'b0, 3'h2, 32'hCAFE0001}));
    // interleaved responses with m1 not ready
    rids[0] = 4'h1; rids[1] = 4'h9; rids[2] = 4'h1;
    m1.rready = 0;
    for (int i = 0; i < 3; i++) begin
      tick; s.rid = rids[i]; s.rdata = 32'(i + 16);
      #2 chk("rint_rdy", 64'(s.rready), 64'(rids[i][3] ? 1'b0 : 1'b1));
      chk("rint_route", 64'({m1.rvalid, m0.rvalid, m0.rdata}), 64'({rids[i][3], ~rids[i][3], 32'(i + 16)}));
    end
    // m1 write with W ahead of AW; m0 arrives mid-burst and must stall
    tick; s.rvalid = 0; s.awready = 1; s.wready = 1;
    m1.wvalid = 1; m1.wdata = 32'hD0; m1.wstrb = 4'hF; m1.wlast = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("w_early", 64'({s.wvalid, m1.wready}), 64'd0);
      tick;
    end
    m1.awvalid = 1; m1.awid = 3'd3; m1.awaddr = 32'h4000; m1.awlen = 8'd3; m1.awburst = 2'd1;
    #2 chk("aw_take", 64'(s.awvalid), 64'd0);
    tick;
    m0.awvalid = 1; m0.awid = 3'd1; m0.awaddr = 32'h5000; m0.awlen = 8'd0;
    m0.wvalid = 1; m0.wdata = 32'hE0; m0.wlast = 1; m0.wstrb = 4'h3;
    #2 chk("aw_m1", 64'({s.awvalid, s.awid, s.awaddr, s.awlen, s.awburst}), 64'({1'b1, 4'hB, 32'h4000, 8'd3, 2'd1}));
    chk("w_m1_b0", 64'({s.wvalid, s.wdata, s.wstrb, m1.wready, m1.awready}), 64'({1'b1, 32'hD0, 4'hF, 1'b1, 1'b1}));
    for (int b = 1; b < 4; b++) begin
      tick; m1.awvalid = 0; m1.wdata = 32'hD0 + 32'(b); m1.wlast = (b == 3);
      #2 chk("w_m1_beat", 64'({s.awvalid, s.wvalid, s.wdata, s.wlast, m1.wready}),
             64'({1'b0, 1'b1, 32'hD0 + 32'(b), b == 3, 1'b1}));
      chk("m0_stall", 64'({m0.awready, m0.wready}), 64'd0);
    end
    tick; m1.wvalid = 0; m1.wlast = 0;
    #2 chk("w_idle_gap", 64'({s.awvalid, s.wvalid}), 64'd0);
    tick;
    #2 chk("aw_m0", 64'({s.awvalid, s.awid, s.wvalid, s.wdata, s.wstrb, s.wlast, m0.awready, m0.wready}),
           64'({1'b1, 4'h1, 1'b1, 32'hE0, 4'h3, 1'b1, 1'b1, 1'b1}));
    // AW and last W completed together: next request must be granted from W_IDLE
    tick; m0.awid = 3'd6; m0.awaddr = 32'h6000; m0.awlen = 8'd7; m0.wdata = 32'hF0; m0.wlast = 0;
    #2 chk("both_done_idle", 64'({s.awvalid, s.wvalid}), 64'd0);
    tick;
    #2 chk("aw_m0_8", 64'({s.awvalid, s.awid, s.awlen}), 64'({1'b1, 4'h6, 8'd7}));
    tick; m0.awvalid = 0; m0.wdata = 32'hF1;
    tick; m0.wdata = 32'hF2;
    m1.awvalid = 1; m1.wvalid = 1; m0.rready = 1; m1.rready = 1; m0.bready = 1; m1.bready = 1;
    s.rvalid = 1; s.bvalid = 1; s.arready = 1;
    rst_n = 0;
    #2 quiet("rst_mid_burst");
    tick;
    m0.awvalid = 1; m0.awid = 3'd2;
    rst_n = 1; s.rvalid = 0; s.bvalid = 0;
    #2 chk("rst_idle", 64'(s.awvalid), 64'd0);
    tick;
    #2 chk("rst_tie_m0", 64'({s.awvalid, s.awid}), 64'({1'b1, 4'h2}));
    // write ID 7 on m1 alongside a read on m0
    rst_n = 0; clr(); tick; rst_n = 1;
    m1.awvalid = 1; m1.awid = 3'd7; m1.awaddr = 32'h7000; m1.wvalid = 1; m1.wlast = 1;
    m0.arvalid = 1; m0.arid = 3'd4; m0.araddr = 32'h8000;
    s.awready = 1; s.arready = 1; s.wready = 1;
    #2 chk("idle_both", 64'({s.awvalid, s.arvalid}), 64'd0);
    tick;
    #2 chk("aw_ar_same", 64'({s.awvalid, s.arvalid, s.awid, s.arid, m1.awready, m0.arready}),
           64'({1'b1, 1'b1, 4'hF, 4'h4, 1'b1, 1'b1}));
    tick; clr();
    s.bvalid = 1; s.bid = 4'hF; s.bresp = AXI_RESP_OKAY; m1.bready = 1;
    #2 chk("b_to_m1", 64'({m1.bvalid, m0.bvalid, m1.bid, m1.bresp, s.bready}), 64'({1'b1, 1'b0, 3'h7, AXI_RESP_OKAY, 1'b1}));
    // randomized read arbitration against the behavioural model
    rst_n = 0; clr(); tick; rst_n = 1;
    mb = 0; mw = 0; mlast = 1; mcnt = 0; req = 2'b00;
    for (int m = 0; m < 2; m++) begin
      q_id[m] = '0; q_ad[m] = '0; q_ln[m] = '0; q_bu[m] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      s_ardy = $urandom_range(0, 3) != 0;
      s.arready = s_ardy;
      m0.arvalid = req[0]; m0.arid = q_id[0]; m0.araddr = q_ad[0]; m0.arlen = q_ln[0]; m0.arburst = q_bu[0];
      m1.arvalid = req[1]; m1.arid = q_id[1]; m1.araddr = q_ad[1]; m1.arlen = q_ln[1]; m1.arburst = q_bu[1];
      #2 chk("rnd_ar_valid", 64'(s.arvalid), 64'(mb & req[mw]));
      if (mb) begin
        chk("rnd_ar_pay", 64'({s.arid, s.araddr, s.arlen, s.arburst}), 64'({mw, q_id[mw], q_ad[mw], q_ln[mw], q_bu[mw]}));
        chk("rnd_ar_rdy", 64'({m1.arready, m0.arready}), 64'(s_ardy ? (mw ? 2'b10 : 2'b01) : 2'b00));
      end
      if (mb && s_ardy) begin
        mb = 0;
        req[mw] = 0;
      end else if (!mb && |req) begin
        mw = pick(req);
        mcnt = mw ? 0 : req[1] ? mcnt + 1 : mcnt;
        mlast = mw;
        mb = 1;
      end
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(0, 2) != 0) begin
          req[m] = 1;
          q_id[m] = 3'($urandom); q_ad[m] = $urandom; q_ln[m] = 8'($urandom); q_bu[m] = 2'($urandom);
        end
      tick;
    end
    // randomized R/B steering
    clr();
    for (int c = 0; c < 80; c++) begin
      rv = 1'($urandom); ri = 4'($urandom); rd = $urandom; rs = 2'($urandom); rl = 1'($urandom);
      rr0 = 1'($urandom); rr1 = 1'($urandom);
      bv = 1'($urandom); bi = 4'($urandom); bs = 2'($urandom); br0 = 1'($urandom); br1 = 1'($urandom);
      s.rvalid = rv; s.rid = ri; s.rdata = rd; s.rresp = rs; s.rlast = rl; m0.rready = rr0; m1.rready = rr1;
      s.bvalid = bv; s.bid = bi; s.bresp = bs; m0.bready = br0; m1.bready = br1;
      #2 chk("rnd_r_vld", 64'({m1.rvalid, m0.rvalid}), 64'({rv & ri[3], rv & ~ri[3]}));
      chk("rnd_r_rdy", 64'(s.rready), 64'(ri[3] ? rr1 : rr0));
      chk("rnd_r_pay", 64'({m0.rid, m1.rid, m0.rresp, m1.rresp, m0.rlast, m1.rlast}), 64'({ri[2:0], ri[2:0], rs, rs, rl, rl}));
      chk("rnd_r_data", {m0.rdata, m1.rdata}, {rd, rd});
      chk("rnd_b_vld", 64'({m1.bvalid, m0.bvalid}), 64'({bv & bi[3], bv & ~bi[3]}));
      chk("rnd_b_rdy", 64'(s.bready), 64'(bi[3] ? br1 : br0));
      chk("rnd_b_pay", 64'({m0.bid, m1.bid, m0.bresp, m1.bresp}), 64'({bi[2:0], bi[2:0], bs, bs}));
      tick;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr3_axi_arb.md
Name: ddr3_axi_arb

Overview:
- Two-master AXI4 arbiter that shares the single AXI4 slave port of the ddr3_top DDR3 controller.
- Read (AR/R) and write (AW/W/B) paths are arbitrated independently, round-robin by default.
- Master index is carried in ID bit 3, so R and B responses are routed back without a tracking FIFO.
- Sits between the CPU/DMA interconnect and ddr3_top, in the same clock domain as ddr3_top `clk`.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- STARVE_MAX, 15, starvation limit for the low-priority master (used only with the optional feature).

Ports:
- clk  in  1  system clock; same clock as ddr3_top.
- rst_n  in  1  asynchronous, active-low reset.
- mN_awid/awaddr/awlen/awburst/awvalid  in  3/ADDR_W/8/2/1  master N write address, N=0,1.
- mN_awready  out  1  master N write-address ready.
- mN_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  master N write data.
- mN_wready  out  1  master N write-data ready.
- mN_bid/bresp/bvalid  out  3/2/1  master N write response.
- mN_bready  in  1  master N write-response ready.
- mN_arid/araddr/arlen/arburst/arvalid  in  3/ADDR_W/8/2/1  master N read address.
- mN_arready  out  1  master N read-address ready.
- mN_rid/rdata/rresp/rlast/rvalid  out  3/DATA_W/2/1/1  master N read data.
- mN_rready  in  1  master N read-data ready.
- s_* (full AXI4 master-side set, ID width 4)  out/in  as ddr3_top axi4_*  connects to ddr3_top.

Behaviour:
- Reset (async, rst_n=0):
  - Every mN_*valid/ready and s_*valid/ready output is 0.
  - Both FSMs go to IDLE.
  - Both round-robin pointers are set to 1, so master 0 wins the first tie.
- Read FSM, states R_IDLE and R_ADDR:
  - R_IDLE: if any mN_arvalid is high, register grant rg and go to R_ADDR next cycle. With both requesting, grant the master that is not the last granted one.
  - R_ADDR: s_arvalid = m[rg]_arvalid. s_araddr/arlen/arburst come from m[rg]. s_arid = {rg, m[rg]_arid}. m[rg]_arready = s_arready; the other master's arready is 0.
  - On the s_ar handshake: update the pointer to rg and return to R_IDLE.
  - Peak rate is 1 AR per 2 cycles. Grant never changes while s_arvalid is high.
- Read return: mN_rvalid = s_rvalid & (s_rid[3]==N). mN_rid = s_rid[2:0]. rdata/rresp/rlast are broadcast to both masters. s_rready = m[s_rid[3]]_rready. Any number of reads may be outstanding.
- Write FSM, states W_IDLE and W_BUSY:
  - W_IDLE: grant wg on any mN_awvalid, using the same round-robin rule.
  - W_BUSY: forward AW from m[wg] with s_awid = {wg, m[wg]_awid}. Forward W from m[wg] at the same time (W may precede, accompany or follow AW).
  - Sticky flags aw_done and w_done; w_done sets on the s_w handshake with s_wlast=1. Go to W_IDLE when both flags are set, including when both set in the same cycle.
  - W of a non-granted master is never accepted.
- Write response: B is routed by s_bid[3], mirroring the R path.
- Simultaneous read and write grants are independent and legal.
- Reset asserted mid-burst: immediate return to IDLE. Any partially forwarded burst is abandoned; system-level reset of ddr3_top is required.
- awlen=0: single-beat burst, wlast on the first beat; no special casing.

Optional Feature:
- Macro: DDR3_AXI_ARB_PRIO_EN.
- Defined:
  - Master 0 has strict priority on both FSMs.
  - A per-path 4-bit starvation counter increments on each grant to master 0 while master 1 is requesting.
  - When the counter reaches STARVE_MAX, master 1 gets the next grant and the counter clears. The counter also clears on any master-1 grant.
- Undefined: pure round-robin as above; counters not instantiated.

Decomposition:
- Package ddr3_axi_arb_pkg: FSM state enums (rd_state_t, wr_state_t), ID_W=4, MID_W=3, AXI_RESP_OKAY constant.
- Sub-module ddr3_axi_arb_rr: 2-way round-robin/priority grant unit with pointer and starvation counter. Instantiated once for read and once for write.

Test Plan:
- Both masters assert arvalid at cycle 0 after reset, m0 arid=5, m1 arid=2 -> m0 granted first with s_arid=4'h5. m1 follows with s_arid=4'hA. R beats with rid=4'hA reach only m1 with rid=3'h2.
- m1 issues a 4-beat write (awlen=3) with W arriving 3 cycles before AW; m0 awvalid arrives mid-burst -> m0's AW and W are stalled until m1's wlast handshake. m0 is granted on the following W_IDLE cycle.
- Interleaved R responses (rid 4'h1, 4'h9, 4'h1) with m1 rready=0 -> s_rready=0 on the 4'h9 beat only; no data loss and no misrouting.
- rst_n pulled low during beat 2 of an 8-beat write -> all valid/ready outputs are 0 in the same cycle. After release, m0 wins the first tie.
- With DDR3_AXI_ARB_PRIO_EN, STARVE_MAX=3, both masters streaming reads -> grant pattern is m0,m0,m0,m1 repeating.
- Write ID 4'hF back-to-back with a read on the other master -> AW and AR handshakes occur in the same cycle; bid 3'h7 is delivered to m1.
